// File: rtl/spi_slave_rx.sv
// SPI receive-only slave. The serial inputs are brought into the clk domain
// through synchronizers, and the edges are detected there. Words arrive LSB
// first and leave on a valid/ready output port. Truncated frames raise a
// one-cycle error pulse, and dropped words raise a sticky overrun flag.
module spi_slave_rx #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             cs,
  input  logic             mosi,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ARM, SHIFT, WAIT_CS} state_t;

  // [0],[1] form the two-flop synchronizer; [2] is the edge-detect history.
  logic [2:0]       sclk_s;
  logic [2:0]       cs_s;
  logic [1:0]       mosi_s;
  // Fills with ones after reset. Edges stay masked until the synchronizer
  // holds real samples, so a cs that is already low cannot fake a falling edge.
  logic [2:0]       primed;

  logic             sclk_fall_q;
  logic             cs_fall_q;
  logic             cs_rise_q;

  state_t           state, state_next;
  logic [CW-1:0]    count, count_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic             frame_err_next;
  logic             word_done, word_done_next;

  // Synchronize the asynchronous serial inputs and track the priming window.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_s <= 3'b000;
      cs_s   <= 3'b111;
      mosi_s <= 2'b00;
      primed <= 3'b000;
    end else begin
      sclk_s <= {sclk_s[1:0], sclk};
      cs_s   <= {cs_s[1:0], cs};
      mosi_s <= {mosi_s[0], mosi};
      primed <= {primed[1:0], 1'b1};
    end
  end

  // Register the edge pulses, comparing the second and third stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_fall_q <= 1'b0;
      cs_fall_q   <= 1'b0;
      cs_rise_q   <= 1'b0;
    end else begin
      sclk_fall_q <= primed[2] &  sclk_s[2] & ~sclk_s[1];
      cs_fall_q   <= primed[2] &  cs_s[2]   & ~cs_s[1];
      cs_rise_q   <= primed[2] & ~cs_s[2]   &  cs_s[1];
    end
  end

  // FSM state, bit counter, shift register and the one-cycle pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      shift_reg <= '0;
      frame_err <= 1'b0;
      word_done <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      shift_reg <= shift_next;
      frame_err <= frame_err_next;
      word_done <= word_done_next;
    end
  end

  // Next-state logic: arm on cs fall, skip one sclk fall, then shift WIDTH bits.
  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    state_next     = state;
    count_next     = count;
    shift_next     = shift_reg;
    frame_err_next = 1'b0;
    word_done_next = 1'b0;
    unique case (state)
      IDLE: begin
        if (cs_fall_q) begin
          state_next = ARM;
          count_next = '0;
          shift_next = '0;
        end
      end
      ARM: begin
        if (cs_rise_q) begin
          frame_err_next = 1'b1;
          state_next     = IDLE;
        end else if (sclk_fall_q) begin
          state_next = SHIFT;
          count_next = '0;
        end
      end
      SHIFT: begin
        if (cs_rise_q) begin
          frame_err_next = 1'b1;
          count_next     = '0;
          shift_next     = '0;
          state_next     = IDLE;
        end else if (sclk_fall_q) begin
          shift_next[count] = mosi_s[1];
          if (count == LAST_BIT) begin
            word_done_next = 1'b1;
            count_next     = '0;
            state_next     = WAIT_CS;
          end else begin
            count_next = count + 1'b1;
          end
        end
      end
      WAIT_CS: begin
        if (cs_rise_q) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output port: load a completed word when free, else drop it and flag overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (word_done) begin
      if (!dout_valid || dout_ready) begin
        dout       <= shift_reg;
        dout_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (dout_valid && dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx. A free-running sclk is driven, and a task
// acts as the SPI master and sends frames. A monitor counts dout_valid rises
// and frame_err pulses, and each test compares those counts and the outputs
// with hand-computed values.
module tb_spi_slave_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk = 1'b0;
  logic        cs = 1'b1;
  logic        mosi = 1'b0;
  logic [11:0] dout;
  logic        dout_valid;
  logic        dout_ready = 1'b0;
  logic        frame_err;
  logic        overrun;

  int tests_run = 0;
  int tests_failed = 0;

  spi_slave_rx #(.WIDTH(12)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // sclk period is 22 clk cycles, and it changes on the falling edge of clk.
  initial begin
    forever begin
      repeat (11) @(negedge clk);
      sclk = ~sclk;
    end
  end

  // Monitor: record every word at its dout_valid rise, and count frame_err activity.
  logic        prev_valid = 1'b0;
  logic        prev_fe = 1'b0;
  int          rises = 0;
  int          fe_cycles = 0;
  int          fe_pulses = 0;
  logic [11:0] words[$];
  always @(negedge clk) begin
    if (dout_valid && !prev_valid) begin
      rises = rises + 1;
      words.push_back(dout);
    end
    if (frame_err) fe_cycles = fe_cycles + 1;
    if (frame_err && !prev_fe) fe_pulses = fe_pulses + 1;
    prev_valid = dout_valid;
    prev_fe    = frame_err;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // SPI master. cs falls during an sclk high phase, and the next sclk fall is
  // a dummy edge. mosi changes on each rising edge and is sampled on the
  // following fall. cs rises after the rising edge that follows the last bit.
  task automatic frame(input logic [11:0] data, input int nbits,
                       input int rst_at, input bit chk_lat);
    @(posedge sclk);
    repeat (3) @(negedge clk);
    cs = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      @(posedge sclk);
      mosi = data[i];
      @(negedge sclk);
      if (rst_at == i + 1) begin
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
      end
      if (chk_lat && i == nbits - 1) begin
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (dout_valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL latency_early: dout_valid=%b at +3 cycles, expected 0", dout_valid);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (dout_valid !== 1'b1) begin
          tests_failed++;
          $display("FAIL latency_exact: dout_valid=%b at +4 cycles, expected 1", dout_valid);
        end
      end
    end
    @(posedge sclk);
    repeat (3) @(negedge clk);
    cs   = 1'b1;
    mosi = 1'b0;
    repeat (30) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (dout_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", dout_valid); end
    tests_run++;
    if (dout !== 12'h000) begin tests_failed++; $display("FAIL reset_dout: got %h expected 000", dout); end
    tests_run++;
    if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    tests_run++;
    if (overrun !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_basic();
    int fe0;
    fe0 = fe_pulses;
    frame(12'hA5C, 12, 0, 1'b1);
    tests_run++;
    if (dout !== 12'hA5C) begin tests_failed++; $display("FAIL basic_dout: got %h expected a5c", dout); end
    tests_run++;
    if (dout_valid !== 1'b1) begin tests_failed++; $display("FAIL basic_valid: got %b expected 1", dout_valid); end
    tests_run++;
    if (fe_pulses - fe0 != 0) begin tests_failed++; $display("FAIL basic_frame_err: got %0d pulses expected 0", fe_pulses - fe0); end
    tests_run++;
    if (overrun !== 1'b0) begin tests_failed++; $display("FAIL basic_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_back_to_back();
    int base;
    do_reset();
    base = rises;
    dout_ready = 1'b1;
    frame(12'h001, 12, 0, 1'b0);
    frame(12'hFFF, 12, 0, 1'b0);
    tests_run++;
    if (rises - base != 2) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d valid rises expected 2", rises - base);
    end else begin
      tests_run++;
      if (words[base] !== 12'h001) begin tests_failed++; $display("FAIL b2b_word0: got %h expected 001", words[base]); end
      tests_run++;
      if (words[base+1] !== 12'hFFF) begin tests_failed++; $display("FAIL b2b_word1: got %h expected fff", words[base+1]); end
    end
    tests_run++;
    if (dout_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_drained: got %b expected 0", dout_valid); end
    dout_ready = 1'b0;
  endtask

  task automatic test_overrun();
    do_reset();
    dout_ready = 1'b0;
    frame(12'h123, 12, 0, 1'b0);
    tests_run++;
    if (dout !== 12'h123 || dout_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovr_first: got dout=%h valid=%b expected 123/1", dout, dout_valid);
    end
    tests_run++;
    if (overrun !== 1'b0) begin tests_failed++; $display("FAIL ovr_early: got %b expected 0", overrun); end
    frame(12'h456, 12, 0, 1'b0);
    tests_run++;
    if (dout !== 12'h123) begin tests_failed++; $display("FAIL ovr_dout_kept: got %h expected 123", dout); end
    tests_run++;
    if (overrun !== 1'b1) begin tests_failed++; $display("FAIL ovr_flag: got %b expected 1", overrun); end
    tests_run++;
    if (dout_valid !== 1'b1) begin tests_failed++; $display("FAIL ovr_valid: got %b expected 1", dout_valid); end
    @(negedge clk);
    dout_ready = 1'b1;
    @(negedge clk);
    dout_ready = 1'b0;
    tests_run++;
    if (dout_valid !== 1'b0) begin tests_failed++; $display("FAIL ovr_consume: got %b expected 0", dout_valid); end
    repeat (5) @(negedge clk);
    tests_run++;
    if (overrun !== 1'b1) begin tests_failed++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
  endtask

  task automatic test_frame_err();
    int fp, fc, rb;
    do_reset();
    fp = fe_pulses;
    fc = fe_cycles;
    rb = rises;
    frame(12'h3C3, 5, 0, 1'b0);
    tests_run++;
    if (fe_pulses - fp != 1) begin tests_failed++; $display("FAIL ferr_pulses: got %0d expected 1", fe_pulses - fp); end
    tests_run++;
    if (fe_cycles - fc != 1) begin tests_failed++; $display("FAIL ferr_width: got %0d cycles expected 1", fe_cycles - fc); end
    tests_run++;
    if (dout_valid !== 1'b0 || rises != rb) begin
      tests_failed++;
      $display("FAIL ferr_no_valid: got valid=%b rises=%0d expected 0/0", dout_valid, rises - rb);
    end
    frame(12'h3C3, 12, 0, 1'b0);
    tests_run++;
    if (dout !== 12'h3C3 || dout_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL ferr_recover: got dout=%h valid=%b expected 3c3/1", dout, dout_valid);
    end
  endtask

  task automatic test_rst_midframe();
    int fp, rb;
    do_reset();
    fp = fe_pulses;
    rb = rises;
    frame(12'hABC, 12, 6, 1'b0);
    tests_run++;
    if (rises != rb || dout_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_no_valid: got rises=%0d valid=%b expected 0/0", rises - rb, dout_valid);
    end
    tests_run++;
    if (fe_pulses != fp) begin tests_failed++; $display("FAIL rstmid_no_ferr: got %0d pulses expected 0", fe_pulses - fp); end
    frame(12'h800, 12, 0, 1'b0);
    tests_run++;
    if (dout !== 12'h800 || dout_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL rstmid_next: got dout=%h valid=%b expected 800/1", dout, dout_valid);
    end
  endtask

  task automatic test_cs_low_at_reset();
    int rb;
    cs = 1'b0;
    do_reset();
    rb = rises;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (i % 22 == 0) mosi = ~mosi;
    end
    tests_run++;
    if (dout_valid !== 1'b0 || rises != rb) begin
      tests_failed++;
      $display("FAIL cslow_no_frame: got valid=%b rises=%0d expected 0/0", dout_valid, rises - rb);
    end
    cs   = 1'b1;
    mosi = 1'b0;
    repeat (10) @(negedge clk);
    tests_run++;
    if (frame_err !== 1'b0 || dout_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL cslow_release: got ferr=%b valid=%b expected 0/0", frame_err, dout_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overrun();
    test_frame_err();
    test_rst_midframe();
    test_cs_low_at_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/spi_slave_rx.md
SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 12, giving the frame length in bits.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port sclk  input  1  serial clock from the SPI master; asynchronous to clk; free-running, including while cs is high.
REQ-005 SHALL have port cs  input  1  chip select, active-low, asynchronous.
REQ-006 SHALL have port mosi  input  1  serial data; changes on sclk rising edges; LSB first.
REQ-007 SHALL have port dout  output  WIDTH  last accepted received word.
REQ-008 SHALL have port dout_valid  output  1  dout holds an unconsumed word.
REQ-009 SHALL have port dout_ready  input  1  consumer accepts dout.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse on a truncated frame.
REQ-011 SHALL have port overrun  output  1  sticky flag: a completed word was dropped.

Function
REQ-012 SHALL pass sclk, cs and mosi each through a 2-flop synchronizer of equal depth.
REQ-013 SHALL derive sclk and cs edges from a third register stage.
REQ-014 SHALL use a state machine with states IDLE, ARM, SHIFT and WAIT_CS.
REQ-015 IDLE -> ARM SHALL occur only on a detected falling edge of synchronized cs; a cs that is already low on leaving reset SHALL NOT start a frame.
REQ-016 ARM SHALL ignore the first synchronized sclk falling edge after cs falls (mosi not yet valid) and then go to SHIFT with bit count 0.
REQ-017 SHIFT SHALL, on each synchronized sclk falling edge, store synchronized mosi into shift-register bit [count] (LSB first) and increment count.
REQ-018 When the WIDTH-th bit is stored, the block SHALL complete the word and go to WAIT_CS.
REQ-019 WAIT_CS SHALL ignore sclk edges and go to IDLE on a detected cs rising edge.
REQ-020 A cs rising edge in ARM or in SHIFT with count < WIDTH SHALL pulse frame_err for exactly one clk cycle, discard the partial word, clear count and go to IDLE.
REQ-021 On word completion with dout_valid=0, or with dout_valid=1 and dout_ready=1 in the same cycle, the block SHALL load dout and set dout_valid on the next clk edge.
REQ-022 On word completion with dout_valid=1 and dout_ready=0, the block SHALL drop the new word, keep dout unchanged and set overrun.
REQ-023 dout_valid SHALL clear on the clk edge where dout_valid=1 and dout_ready=1 with no simultaneous completion.
REQ-024 dout SHALL stay stable while dout_valid=1.
REQ-025 overrun SHALL stay at 1 until rst.
REQ-026 dout_valid SHALL rise exactly 4 clk cycles after the first clk edge that samples raw sclk low for the WIDTH-th sampling edge (2 sync + 1 edge + 1 load).
REQ-027 The block SHALL operate correctly for sclk periods of at least 8 clk cycles with a high/low phase of at least 4 clk cycles each.

Reset
REQ-028 On rst=1 at a clk edge, the block SHALL go to IDLE, clear count and the shift register, and set dout=0, dout_valid=0, frame_err=0 and overrun=0.
REQ-029 On reset, the synchronizer stages SHALL reset to sclk=0, cs=1 and mosi=0.
REQ-030 rst asserted mid-frame SHALL abort the frame without a frame_err pulse; the next frame SHALL start only after a fresh cs falling edge.

Verification
REQ-031 Drive a master with 22-clk sclk period sending 12'hA5C (LSB first, cs low for 13 sclk rising edges) -> dout=12'hA5C, dout_valid=1, frame_err=0, overrun=0.
REQ-032 Send 12'h001 then 12'hFFF with dout_ready tied to 1 -> two dout_valid assertions, carrying 12'h001 then 12'hFFF.
REQ-033 Send 12'h123 with dout_ready=0, then send 12'h456 -> dout stays 12'h123 and overrun=1; then pulse dout_ready -> dout_valid=0.
REQ-034 Raise cs after 5 data bits -> frame_err pulses for exactly 1 cycle, dout_valid stays 0, and the next full frame 12'h3C3 is received correctly.
REQ-035 Assert rst for 2 cycles after 6 data bits while cs stays low, then release -> no dout_valid for that frame and no frame_err; the following frame 12'h800 is received correctly.
REQ-036 Hold cs low with no falling edge after reset, with sclk toggling -> dout_valid stays 0.
